// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its dump streamer.
package dmem_pkg;

    localparam int DEFAULT_N     = 64;
    localparam int DEFAULT_DEPTH = 64;
    localparam int WORD_BYTES    = 8;
    // Widest index needed for the largest supported array (1024 words).
    localparam int IDX_MAX_W     = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_t;

    // Byte address to word index; the low three byte-lane bits are dropped.
    function automatic logic [IDX_MAX_W-1:0] word_index(input logic [IDX_MAX_W+2:0] addr,
                                                        input int idx_w);
        logic [IDX_MAX_W-1:0] raw;
        raw = IDX_MAX_W'(addr >> 3);
        return raw & IDX_MAX_W'((1 << idx_w) - 1);
    endfunction

endpackage

// File: rtl/dmem_dump_fsm.sv
// Dump sequencer: edge-detects the dump request and walks the array one word per
// accepted beat, holding a registered snapshot of the presented word.
module dmem_dump_fsm
    import dmem_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dump_i,
    input  logic             ready_i,
    input  logic [N-1:0]     rd_data_i,
    output logic [IDX_W-1:0] rd_idx_o,
    output dump_state_t      state_o,
    output logic [N-1:0]     addr_o,
    output logic [N-1:0]     data_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Handshake: a word transfers on a rising edge where valid (state STREAM)
    // and ready_i are both high; while ready_i is low addr/data stay frozen.
    dump_state_t      state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     data_q, data_d;
    logic [N-1:0]     addr_q, addr_d;
    logic             dump_q;
    logic             start;
    logic [IDX_W-1:0] ptr_next;

    assign start    = dump_i & ~dump_q;
    assign ptr_next = ptr_q + IDX_W'(1);
    // The array port always looks one word ahead so the next snapshot is ready.
    assign rd_idx_o = (state_q == STREAM) ? ptr_next : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = '0;
                    data_d  = rd_data_i;
                    addr_d  = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (ready_i) begin
                    if (ptr_q != LAST_IDX) begin
                        ptr_d  = ptr_next;
                        data_d = rd_data_i;
                        addr_d = N'({ptr_next, 3'b000});
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!dump_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            dump_q  <= dump_i;
        end
    end

    assign state_o = state_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dmem_dump_responder.sv
// Word-addressed data memory for the CPU with a combinational read port and a
// valid/ready dump stream of the whole array.
module dmem_dump_responder
    import dmem_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    output logic [N-1:0] DM_readData,
    output logic         DM_oob,
    input  logic         dump,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [N-1:0] dump_addr,
    output logic [N-1:0] dump_data,
    output logic         dump_done
);

    localparam int           IDX_W     = $clog2(DEPTH);
    localparam logic [N-1:0] MEM_BYTES = N'(DEPTH * WORD_BYTES);

    logic [N-1:0]     mem_q [DEPTH];
    logic [IDX_W-1:0] cpu_idx;
    logic             wr_en;
    logic [IDX_W-1:0] snap_idx;
    logic [N-1:0]     snap_data;
    dump_state_t      fsm_state;

    assign cpu_idx     = IDX_W'(word_index(DM_addr[IDX_MAX_W+2:0], IDX_W));
    assign DM_oob      = (DM_addr >= MEM_BYTES);
    assign wr_en       = DM_writeEnable & ~DM_oob;
    assign DM_readData = DM_oob ? '0 : mem_q[cpu_idx];

    // Write-first bypass so a snapshot taken on the same edge as a write sees the new word.
    assign snap_data = (wr_en && (cpu_idx == snap_idx)) ? DM_writeData : mem_q[snap_idx];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[cpu_idx] <= DM_writeData;
        end
    end

    dmem_dump_fsm #(
        .N     (N),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fsm (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .dump_i    (dump),
        .ready_i   (dump_ready),
        .rd_data_i (snap_data),
        .rd_idx_o  (snap_idx),
        .state_o   (fsm_state),
        .addr_o    (dump_addr),
        .data_o    (dump_data)
    );

    assign dump_valid = (fsm_state == STREAM);
    assign dump_done  = (fsm_state == DONE);

endmodule

// File: doc/dmem_dump_responder.md
Name: dmem_dump_responder

Overview:
- Data-memory responder at the far end of the processor's DM write/address interface (DM_addr, DM_writeData, DM_writeEnable, dump).
- Services word writes and combinational reads from the CPU.
- On a dump request, streams the whole array out over a valid/ready port so benches and the FPGA debug path can capture final memory state.
- Sits beside processor_arm in the top level.

Parameters:
- N, 64, data and address width in bits.
- DEPTH, 64, number of N-bit words; power of two, 2..1024.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- DM_addr  in  N  byte address from the CPU.
- DM_writeData  in  N  write data.
- DM_writeEnable  in  1  write strobe.
- DM_readData  out  N  combinational read data.
- DM_oob  out  1  DM_addr is out of range (combinational).
- dump  in  1  dump request, level input.
- dump_valid  out  1  dump word present.
- dump_ready  in  1  sink accepts the word.
- dump_addr  out  N  byte address of the presented word.
- dump_data  out  N  word contents.
- dump_done  out  1  dump complete.

Behaviour:
- Addressing: word index = DM_addr[log2(DEPTH)+2:3]; DM_addr[2:0] ignored.
- DM_oob = 1 when DM_addr >= DEPTH*8.
- Writes: at the clock edge with DM_writeEnable=1 and DM_oob=0, mem[idx] <= DM_writeData. An oob write is dropped with no side effect.
- Reads: DM_readData = mem[idx] combinationally, 0 when DM_oob. Latency is zero, so a write becomes visible on the cycle after its edge.
- Reset (asynchronous):
  - all mem words = 0.
  - FSM = IDLE; dump_q = 0.
  - dump_valid = 0, dump_done = 0, dump_addr = 0, dump_data = 0.
- Dump edge detect: dump_q registers dump. start = dump & ~dump_q.
- FSM states IDLE, STREAM, DONE:
  - IDLE: on start, load ptr = 0, dump_data <= mem[0], dump_addr <= 0, dump_valid <= 1 -> STREAM.
  - STREAM, dump_ready=1 and ptr < DEPTH-1: ptr+1; dump_data <= mem[ptr+1]; dump_addr <= (ptr+1)*8; dump_valid stays 1.
  - STREAM, dump_ready=1 and ptr = DEPTH-1: dump_valid <= 0, dump_done <= 1 -> DONE.
  - STREAM, dump_ready=0: dump_addr and dump_data held stable (registered snapshot).
  - DONE: dump_done held at 1 while dump=1. When dump=0: dump_done <= 0 -> IDLE.
  - A new start is honoured only from IDLE. A level held high never retriggers.
- Write/dump collision:
  - A write in the same cycle as a snapshot load of the same index loads DM_writeData (write-first bypass).
  - Writes to already-streamed words are not re-emitted.
  - Writes to the currently presented word do not alter the held dump_data.
- CPU writes remain fully serviced in every FSM state; the dump never stalls the CPU.
- Reset mid-dump aborts immediately: outputs return to reset values and memory is cleared.
- ptr width is log2(DEPTH). No wrap occurs, because termination happens at DEPTH-1.

Decomposition:
- Shared package dmem_pkg:
  - default N and DEPTH localparams.
  - WORD_BYTES = 8.
  - typedef enum logic [1:0] {IDLE, STREAM, DONE} dump_state_t.
  - function word_index(addr).
- One sub-module, dmem_dump_fsm: edge detect, state, ptr, valid/done. It takes the array read port by index. The array and CPU port stay in the top.

Test Plan:
- Reset with dump=0 -> DM_readData=0 for addr 0..504; dump_valid=0, dump_done=0.
- Write 0xA5 @addr 16; next cycle read addr 16 and addr 19 -> 0xA5 both; read addr 24 -> 0.
- Write 0xDEAD @addr 512 (DEPTH=64) -> DM_oob=1, mem unchanged, DM_readData=0.
- Preload mem[k]=k+1 for all k, pulse dump, dump_ready=1 -> 64 consecutive valid beats, addr 0,8,...,504, data 1..64; dump_done=1 next cycle; after dump=0, dump_done=0.
- Same preload, dump_ready toggling 1,0,0,1 -> dump_data/dump_addr stable during stalls; no beat lost or duplicated; still 64 beats.
- Assert reset on beat 10 of a dump -> dump_valid=0 asynchronously, mem cleared; a new dump pulse streams all zeros.
